sn74xx_mux_reg: RTL and testbench

//  Parametrised registered data selector: the successor of the quad 2-to-1 '157 selector.

---
 rtl/sn74xx_mux_reg.sv | 108 ++++++++++
 tb/tb_sn74xx_mux_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sn74xx_mux_reg.sv
// Registered CHANNELS-to-1 data selector with strobe blanking and an auto-scan
// mode that steps through the channels, dwelling dwell+1 enabled cycles on each.
module sn74xx_mux_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1,
    parameter int DWELL_W  = 4
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      str_n,
    input  logic                      mode,
    input  logic                      load,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          q,
    output logic [SEL_W-1:0]          q_ch,
    output logic                      q_vld,
    output logic                      scan_wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_CNT  = (SEL_W + 1)'(CHANNELS);

    logic [WIDTH-1:0]   q_q,         q_d;
    logic [SEL_W-1:0]   q_ch_q,      q_ch_d;
    logic               q_vld_q,     q_vld_d;
    logic               scan_wrap_q, scan_wrap_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;
    logic [DWELL_W-1:0] dc_q,        dc_d;
    logic               mode_d_q,    mode_d_d;
    logic               scan_entry_s;

    assign scan_entry_s = mode & ~mode_d_q;

    // Next-state selection: strobe blanks, manual loads, scan steps on dwell expiry.
    always_comb begin
        q_d         = q_q;
        q_ch_d      = q_ch_q;
        q_vld_d     = 1'b0;
        scan_wrap_d = 1'b0;
        ptr_d       = ptr_q;
        dc_d        = dc_q;
        mode_d_d    = mode;

        if (str_n) begin
            q_d = {WIDTH{1'b0}};
        end else if (!mode) begin
            if (load && ({1'b0, sel} < CH_CNT)) begin
                q_d     = din[int'(sel)*WIDTH +: WIDTH];
                q_ch_d  = sel;
                q_vld_d = 1'b1;
            end else begin
                q_d = q_q;
            end
        end else if (scan_entry_s) begin
            q_d = q_q;
        end else begin
            // >= rather than == so a lowered dwell cannot strand dc above it
            if (dc_q >= dwell) begin
                q_d         = din[int'(ptr_q)*WIDTH +: WIDTH];
                q_ch_d      = ptr_q;
                q_vld_d     = 1'b1;
                dc_d        = {DWELL_W{1'b0}};
                scan_wrap_d = (ptr_q == LAST_CH);
                ptr_d       = (ptr_q == LAST_CH) ? {SEL_W{1'b0}} : ptr_q + SEL_W'(1);
            end else begin
                dc_d = dc_q + DWELL_W'(1);
            end
        end

        // Scan restart on mode entry applies even while strobed
        if (scan_entry_s) begin
            ptr_d = {SEL_W{1'b0}};
            dc_d  = {DWELL_W{1'b0}};
        end else begin
            ptr_d = ptr_d;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q         <= {WIDTH{1'b0}};
            q_ch_q      <= {SEL_W{1'b0}};
            q_vld_q     <= 1'b0;
            scan_wrap_q <= 1'b0;
            ptr_q       <= {SEL_W{1'b0}};
            dc_q        <= {DWELL_W{1'b0}};
            mode_d_q    <= 1'b0;
        end else begin
            q_q         <= q_d;
            q_ch_q      <= q_ch_d;
            q_vld_q     <= q_vld_d;
            scan_wrap_q <= scan_wrap_d;
            ptr_q       <= ptr_d;
            dc_q        <= dc_d;
            mode_d_q    <= mode_d_d;
        end
    end

    assign q         = q_q;
    assign q_ch      = q_ch_q;
    assign q_vld     = q_vld_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_sn74xx_mux_reg.sv
// Directed bench for sn74xx_mux_reg: three instances cover the 2-, 4- and
// 3-channel configurations sharing one clock and clear.
module tb_sn74xx_mux_reg;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 2-channel instance
    logic [7:0] din2;
    logic       sel2, str2, mode2, load2;
    logic [3:0] dwell2, q2;
    logic       qch2, vld2, wrap2;

    // 4-channel instance
    logic [15:0] din4;
    logic [1:0]  sel4, qch4;
    logic        str4, mode4, load4;
    logic [3:0]  dwell4, q4;
    logic        vld4, wrap4;

    // 3-channel instance
    logic [11:0] din3;
    logic [1:0]  sel3, qch3;
    logic        str3, mode3, load3;
    logic [3:0]  dwell3, q3;
    logic        vld3, wrap3;

    sn74xx_mux_reg #(.WIDTH(4), .CHANNELS(2), .SEL_W(1), .DWELL_W(4)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .din(din2), .sel(sel2), .str_n(str2), .mode(mode2),
        .load(load2), .dwell(dwell2), .q(q2), .q_ch(qch2), .q_vld(vld2), .scan_wrap(wrap2));

    sn74xx_mux_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL_W(4)) u_dut4 (
        .clk(clk), .clr_n(clr_n), .din(din4), .sel(sel4), .str_n(str4), .mode(mode4),
        .load(load4), .dwell(dwell4), .q(q4), .q_ch(qch4), .q_vld(vld4), .scan_wrap(wrap4));

    sn74xx_mux_reg #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL_W(4)) u_dut3 (
        .clk(clk), .clr_n(clr_n), .din(din3), .sel(sel3), .str_n(str3), .mode(mode3),
        .load(load3), .dwell(dwell3), .q(q3), .q_ch(qch3), .q_vld(vld3), .scan_wrap(wrap3));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        din2 = 8'h5a;  sel2 = 1'b0; str2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; dwell2 = 4'd0;
        din4 = 16'h4321; sel4 = 2'd0; str4 = 1'b0; mode4 = 1'b0; load4 = 1'b0; dwell4 = 4'd2;
        din3 = 12'hcb7; sel3 = 2'd0; str3 = 1'b0; mode3 = 1'b0; load3 = 1'b0; dwell3 = 4'd7;

        #1;
        check_val("rst_q",   32'(q2),   32'h0);
        check_val("rst_qch", 32'(qch2), 32'h0);
        check_val("rst_vld", 32'(vld2), 32'h0);
        #10 clr_n = 1'b1;

        // Manual capture on the 2-channel part
        sel2 = 1'b0; load2 = 1'b1; tick();
        check_val("man_ch0_q",   32'(q2),   32'ha);
        check_val("man_ch0_vld", 32'(vld2), 32'h1);
        sel2 = 1'b1; tick();
        check_val("man_ch1_q",   32'(q2),   32'h5);
        check_val("man_ch1_qch", 32'(qch2), 32'h1);
        load2 = 1'b0; din2 = 8'h33; tick();
        check_val("hold_q",   32'(q2),   32'h5);
        check_val("hold_vld", 32'(vld2), 32'h0);
        din2 = 8'h5a;

        // Strobe blanks output even with load asserted
        str2 = 1'b1; load2 = 1'b1; tick();
        check_val("str_q",   32'(q2),   32'h0);
        check_val("str_vld", 32'(vld2), 32'h0);
        check_val("str_qch", 32'(qch2), 32'h1);
        str2 = 1'b0; sel2 = 1'b0; tick();
        check_val("str_resume_q",   32'(q2),   32'ha);
        check_val("str_resume_vld", 32'(vld2), 32'h1);

        // Scan dwell=0: entry cycle, then a,5,a,5
        load2 = 1'b0; mode2 = 1'b1; dwell2 = 4'd0; tick();
        check_val("entry_vld", 32'(vld2), 32'h0);
        check_val("entry_q",   32'(q2),   32'ha);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("scan0_q",    32'(q2),    (i % 2 == 0) ? 32'ha : 32'h5);
            check_val("scan0_vld",  32'(vld2),  32'h1);
            check_val("scan0_wrap", 32'(wrap2), (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        mode2 = 1'b0; tick();
        check_val("leave_q",   32'(q2),   32'h5);
        check_val("leave_vld", 32'(vld2), 32'h0);

        // Asynchronous clear mid-cycle
        #2 clr_n = 1'b0; #1;
        check_val("midrst_q",   32'(q2),   32'h0);
        check_val("midrst_qch", 32'(qch2), 32'h0);
        check_val("midrst_vld", 32'(vld2), 32'h0);
        #3 clr_n = 1'b1;

        // 4-channel scan, dwell=2: captures on edges 4,7,10,13,16 after mode rise
        mode4 = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e >= 4 && ((e - 4) % 3 == 0)) begin
                check_val("scan4_vld",  32'(vld4),  32'h1);
                check_val("scan4_q",    32'(q4),    32'(((e - 4) / 3) % 4 + 1));
                check_val("scan4_wrap", 32'(wrap4), (e == 13) ? 32'h1 : 32'h0);
            end else begin
                check_val("scan4_idle_vld", 32'(vld4), 32'h0);
            end
        end
        tick();
        check_val("scan4_pre_str_vld", 32'(vld4), 32'h0);
        str4 = 1'b1;
        tick(); check_val("scan4_str_q", 32'(q4), 32'h0);
        tick(); check_val("scan4_str_vld", 32'(vld4), 32'h0);
        str4 = 1'b0;
        tick(); check_val("scan4_delay_vld", 32'(vld4), 32'h0);
        tick();
        check_val("scan4_after_str_q",   32'(q4),   32'h2);
        check_val("scan4_after_str_vld", 32'(vld4), 32'h1);

        // 3-channel: out-of-range select is ignored
        sel3 = 2'd2; load3 = 1'b1; tick();
        check_val("ch3_sel2_q", 32'(q3), 32'hc);
        sel3 = 2'd3; tick();
        check_val("ch3_sel3_vld", 32'(vld3), 32'h0);
        check_val("ch3_sel3_q",   32'(q3),   32'hc);
        check_val("ch3_sel3_qch", 32'(qch3), 32'h2);

        // Dwell lowered from 7 to 1 while dc=5 forces capture next edge
        load3 = 1'b0; mode3 = 1'b1; dwell3 = 4'd7; tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("dwell7_vld", 32'(vld3), 32'h0);
        end
        dwell3 = 4'd1; tick();
        check_val("dwell_drop_vld", 32'(vld3),  32'h1);
        check_val("dwell_drop_q",   32'(q3),    32'h7);
        check_val("dwell_drop_qch", 32'(qch3),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
